// File: rtl/mem_wb_skid_pkg.sv
// Shared types and constants for the MEM/WB skid stage.
// Imported by the payload slot and the stage top.
package mem_wb_skid_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic ZERO_BIT      = 1'b0;
    localparam logic WRITE_DISABLE = 1'b0;

    function automatic logic [1:0] occupancy(input state_t s);
        return s;
    endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One LANES-wide writeback payload register with clear, load and
// the optional x0-write mask applied at capture.
import mem_wb_skid_pkg::*;

module mem_wb_slot #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int LANES     = 1,
    parameter int ZERO_MASK = 1
) (
    input  logic                    clk,
    input  logic                    i_clr,
    input  logic                    i_load,
    input  logic [LANES*DATA_W-1:0] i_data,
    input  logic [LANES*ADDR_W-1:0] i_addr,
    input  logic [LANES-1:0]        i_en,
    output logic [LANES*DATA_W-1:0] o_data,
    output logic [LANES*ADDR_W-1:0] o_addr,
    output logic [LANES-1:0]        o_en
);

    logic [LANES-1:0] w_en;

    // A write to x0 is architecturally a no-op, so drop its enable.
    always_comb begin
        w_en = i_en;
        for (int k = 0; k < LANES; k++) begin
            if (ZERO_MASK != 0 && i_addr[k*ADDR_W +: ADDR_W] == '0) begin
                w_en[k] = ZERO_BIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            o_data <= '0;
            o_addr <= '0;
            o_en   <= {LANES{WRITE_DISABLE}};
        end else if (i_load) begin
            o_data <= i_data;
            o_addr <= i_addr;
            o_en   <= w_en;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB stage register with a 2-entry skid buffer, flush and
// occupancy; in_ready_o is registered to cut the WB->MEM path.
import mem_wb_skid_pkg::*;

module mem_wb_skid #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int LANES     = 1,
    parameter int ZERO_MASK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*DATA_W-1:0] rd_data_i,
    input  logic [LANES*ADDR_W-1:0] rd_addr_i,
    input  logic [LANES-1:0]        rd_enable_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*DATA_W-1:0] rd_data_o,
    output logic [LANES*ADDR_W-1:0] rd_addr_o,
    output logic [LANES-1:0]        rd_enable_o,
    output logic [1:0]              count_o
);

    state_t r_state;
    logic   r_out_valid;
    logic   r_in_ready;
    logic   [1:0] r_count;

    logic w_clr, w_accept, w_take;
    logic w_empty, w_one, w_two;
    logic w_main_load, w_main_clr;
    logic w_skid_load, w_skid_clr;

    logic [LANES*DATA_W-1:0] w_skid_data, w_main_data;
    logic [LANES*ADDR_W-1:0] w_skid_addr, w_main_addr;
    logic [LANES-1:0]        w_skid_en, w_main_en;

    assign w_clr    = rst | flush_i;
    assign w_accept = in_valid_i & r_in_ready;
    assign w_take   = r_out_valid & out_ready_i;
    assign w_empty  = (r_state == S_EMPTY);
    assign w_one    = (r_state == S_ONE);
    assign w_two    = (r_state == S_TWO);

    assign w_main_load = ~w_clr & ((w_empty & w_accept) |
                                   (w_one & w_accept & w_take) |
                                   (w_two & w_take));
    // Main is cleared when it drains so idle outputs read as zero.
    assign w_main_clr  = w_clr | (w_one & ~w_accept & w_take);
    assign w_skid_load = ~w_clr & w_one & w_accept & ~w_take;
    assign w_skid_clr  = w_clr | (w_two & w_take);

    assign w_main_data = w_two ? w_skid_data : rd_data_i;
    assign w_main_addr = w_two ? w_skid_addr : rd_addr_i;
    assign w_main_en   = w_two ? w_skid_en   : rd_enable_i;

    mem_wb_slot #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .LANES(LANES), .ZERO_MASK(ZERO_MASK)
    ) u_skid (
        .clk(clk), .i_clr(w_skid_clr), .i_load(w_skid_load),
        .i_data(rd_data_i), .i_addr(rd_addr_i), .i_en(rd_enable_i),
        .o_data(w_skid_data), .o_addr(w_skid_addr), .o_en(w_skid_en)
    );

    mem_wb_slot #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .LANES(LANES), .ZERO_MASK(ZERO_MASK)
    ) u_main (
        .clk(clk), .i_clr(w_main_clr), .i_load(w_main_load),
        .i_data(w_main_data), .i_addr(w_main_addr), .i_en(w_main_en),
        .o_data(rd_data_o), .o_addr(rd_addr_o), .o_en(rd_enable_o)
    );

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_count     <= occupancy(S_EMPTY);
        end else begin
            unique case (1'b1)
                w_empty: if (w_accept) begin
                    r_state     <= S_ONE;
                    r_out_valid <= 1'b1;
                    r_count     <= occupancy(S_ONE);
                end
                w_one: if (w_accept && !w_take) begin
                    r_state    <= S_TWO;
                    r_in_ready <= 1'b0;
                    r_count    <= occupancy(S_TWO);
                end else if (!w_accept && w_take) begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_count     <= occupancy(S_EMPTY);
                end
                w_two: if (w_take) begin
                    r_state    <= S_ONE;
                    r_in_ready <= 1'b1;
                    r_count    <= occupancy(S_ONE);
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_count     <= occupancy(S_EMPTY);
                end
            endcase
        end
    end

    assign out_valid_o = r_out_valid;
    assign in_ready_o  = r_in_ready;
    assign count_o     = r_count;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Bench for mem_wb_skid (LANES=2): directed scenarios with literal
// expectations plus random traffic against a FIFO reference model.
module tb_mem_wb_skid;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int L  = 2;

    typedef struct {
        logic [L*DW-1:0] data;
        logic [L*AW-1:0] addr;
        logic [L-1:0]    en;
    } ent_t;

    logic            clk = 0;
    logic            rst = 1;
    logic            flush = 0;
    logic            in_valid = 0;
    logic            in_ready;
    logic [L*DW-1:0] d_in = '0;
    logic [L*AW-1:0] a_in = '0;
    logic [L-1:0]    e_in = '0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [L*DW-1:0] d_out;
    logic [L*AW-1:0] a_out;
    logic [L-1:0]    e_out;
    logic [1:0]      cnt;

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;
    ent_t q[$];

    mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .ZERO_MASK(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rd_data_i(d_in), .rd_addr_i(a_in), .rd_enable_i(e_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_data_o(d_out), .rd_addr_o(a_out), .rd_enable_o(e_out),
        .count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic ent_t capture(input logic [L*DW-1:0] d, input logic [L*AW-1:0] a,
                                     input logic [L-1:0] e);
        ent_t x;
        x.data = d;
        x.addr = a;
        for (int k = 0; k < L; k++)
            x.en[k] = e[k] && (a[k*AW +: AW] != 0);
        return x;
    endfunction

    // Reference: an ordered queue of at most two entries.
    always @(posedge clk) begin
        bit tk, ac;
        if (rst || flush) begin
            q.delete();
        end else begin
            tk = (q.size() > 0) && out_ready;
            ac = in_valid && (q.size() < 2);
            if (tk) void'(q.pop_front());
            if (ac) q.push_back(capture(d_in, a_in, e_in));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0) begin
                chk("m_valid", 64'(out_valid), 64'd1);
                chk("m_data", 64'(d_out), 64'(q[0].data));
                chk("m_addr", 64'(a_out), 64'(q[0].addr));
                chk("m_en", 64'(e_out), 64'(q[0].en));
            end else begin
                chk("m_valid", 64'(out_valid), 64'd0);
                chk("m_data", 64'(d_out), 64'd0);
                chk("m_addr", 64'(a_out), 64'd0);
                chk("m_en", 64'(e_out), 64'd0);
            end
            chk("m_count", 64'(cnt), 64'(q.size()));
            chk("m_ready", 64'(in_ready), 64'(q.size() < 2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d0, input logic [4:0] a0);
        in_valid = 1;
        d_in = {32'h0, d0};
        a_in = {5'd0, a0};
        e_in = 2'b01;
    endtask

    initial begin
        // Reset with an input offered
        rst = 1; in_valid = 1;
        d_in = {2{32'hDEADBEEF}}; a_in = {5'd5, 5'd5}; e_in = 2'b11;
        out_ready = 1;
        step(); chk_en = 1;
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_en", 64'(e_out), 64'd0);
        rst = 0; in_valid = 0;
        step();
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            offer(32'h100 + 32'(i), 5'(i + 1));
            step();
            chk("str_data", 64'(d_out[31:0]), 64'h100 + 64'(i));
            chk("str_addr", 64'(a_out[4:0]), 64'(i + 1));
            chk("str_count", 64'(cnt), 64'd1);
        end
        in_valid = 0;
        step();
        chk("str_drain", 64'(out_valid), 64'd0);

        // Backpressure with A, B, then C waiting
        out_ready = 0;
        offer(32'h11, 5'd1); step();
        offer(32'h22, 5'd2); step();
        chk("bp_count2", 64'(cnt), 64'd2);
        chk("bp_ready0", 64'(in_ready), 64'd0);
        offer(32'h33, 5'd3); step(); step();
        chk("bp_holdA", 64'(d_out[31:0]), 64'h11);
        out_ready = 1; step();
        chk("bp_B", 64'(d_out[31:0]), 64'h22);
        step();
        chk("bp_C", 64'(d_out[31:0]), 64'h33);
        in_valid = 0; step();
        chk("bp_empty", 64'(cnt), 64'd0);

        // Flush while full, input offered in the flush cycle
        out_ready = 0;
        offer(32'h11, 5'd1); step();
        offer(32'h22, 5'd2); step();
        flush = 1; offer(32'h44, 5'd4); step();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_en", 64'(e_out), 64'd0);
        chk("fl_count", 64'(cnt), 64'd0);
        flush = 0; in_valid = 0; step();
        chk("fl_dropped", 64'(out_valid), 64'd0);

        // x0 mask on lane 0
        in_valid = 1; d_in = {32'hBB, 32'hAA}; a_in = {5'd3, 5'd0}; e_in = 2'b11;
        step();
        chk("zm_en", 64'(e_out), 64'b10);
        chk("zm_addr", 64'(a_out), 64'({5'd3, 5'd0}));
        chk("zm_data", 64'(d_out), {32'hBB, 32'hAA});
        in_valid = 0; out_ready = 1; step();

        // Accept and take together, then reset from full
        out_ready = 0; offer(32'h55, 5'd4); step();
        out_ready = 1; offer(32'h66, 5'd6); step();
        chk("sim_Y", 64'(d_out[31:0]), 64'h66);
        chk("sim_count", 64'(cnt), 64'd1);
        out_ready = 0; offer(32'h77, 5'd7); step();
        chk("sim_two", 64'(cnt), 64'd2);
        rst = 1; step();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_data", 64'(d_out), 64'd0);
        chk("mr_count", 64'(cnt), 64'd0);
        rst = 0; out_ready = 1; offer(32'h88, 5'd8); step();
        chk("mr_first", 64'(d_out[31:0]), 64'h88);
        chk("mr_valid1", 64'(out_valid), 64'd1);

        // Random traffic; garbage inputs while in_valid is low
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            d_in      = {$urandom, $urandom};
            a_in      = 10'($urandom);
            e_in      = 2'($urandom);
            step();
        end
        rst = 0; flush = 0; in_valid = 0;
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
